// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Hazard and flow controller beside decode. Compares NSRC decode source
//   registers against NSTAGE downstream writeback stages, either forwarding
//   ready results (FWD_EN=1) or stalling, and sequences fixed-length bubble
//   windows for redirects, interrupts and reset release.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   src_addr/src_rd     decode source registers and their read enables
//   stg_waddr/stg_wen   destination register and write enable per stage
//   stg_ready           stage result can be forwarded
//   instr_type          decode type (6 = call, 7..9 = return class)
//   branch_miss         resolved misprediction
//   pred_taken          predictor taken
//   interrupt/int_enable level interrupt request and enable flag
//   instr_pc_mux_sel    decode-supplied PC source
//   fwd_sel             per source: 0 = regfile, k+1 = stage k
//   stall               hold PC, fetch latch and imem address mux
//   dec_nop, dec_int    squash decode / inject interrupt op
//   pc_inc/load/reset   PC controls
//   pc_mux_sel          PC source select
module pipeline_hazard_unit #(
  parameter int REG_AW           = 5,
  parameter int NSRC             = 2,
  parameter int NSTAGE           = 2,
  parameter int FWD_EN           = 1,
  parameter int REDIRECT_BUBBLES = 2,
  parameter int INT_BUBBLES      = 3,
  parameter int RESET_BUBBLES    = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NSRC*REG_AW-1:0]                 src_addr,
  input  logic [NSRC-1:0]                        src_rd,
  input  logic [NSTAGE*REG_AW-1:0]               stg_waddr,
  input  logic [NSTAGE-1:0]                      stg_wen,
  input  logic [NSTAGE-1:0]                      stg_ready,
  input  logic [3:0]                             instr_type,
  input  logic                                   branch_miss,
  input  logic                                   pred_taken,
  input  logic                                   interrupt,
  input  logic                                   int_enable,
  input  logic [1:0]                             instr_pc_mux_sel,
  output logic [NSRC*$clog2(NSTAGE+1)-1:0]       fwd_sel,
  output logic                                   stall,
  output logic                                   dec_nop,
  output logic                                   dec_int,
  output logic                                   pc_inc,
  output logic                                   pc_load,
  output logic                                   pc_reset,
  output logic [2:0]                             pc_mux_sel
);

  localparam int FW    = $clog2(NSTAGE + 1);
  localparam int MAXB0 = (REDIRECT_BUBBLES > INT_BUBBLES) ? REDIRECT_BUBBLES : INT_BUBBLES;
  localparam int MAXB  = (MAXB0 > RESET_BUBBLES) ? MAXB0 : RESET_BUBBLES;
  localparam int CW    = $clog2(MAXB + 1);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_PRED  = 3'd1,
    S_FLUSH = 3'd2,
    S_INT   = 3'd3,
    S_RST   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                raw;
  logic [NSRC-1:0]     seen;
  logic [NSRC*FW-1:0]  fwd_cand;
  logic                call_ret;
  logic                pred_take;

  assign call_ret = (instr_type == 4'd6) || (instr_type == 4'd7) ||
                    (instr_type == 4'd8) || (instr_type == 4'd9);

  // Hazard detection: the youngest matching stage (lowest k) decides whether
  // a source forwards or raises a RAW hazard; older matches are shadowed.
  always_comb begin
    raw      = 1'b0;
    seen     = '0;
    fwd_cand = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (!seen[s] && src_rd[s] && stg_wen[k] &&
            (src_addr[s*REG_AW +: REG_AW] == stg_waddr[k*REG_AW +: REG_AW])) begin
          seen[s] = 1'b1;
          if ((FWD_EN != 0) && stg_ready[k]) begin
            fwd_cand[s*FW +: FW] = FW'(k + 1);
          end else begin
            raw = 1'b1;
          end
        end
      end
    end
  end

  // Flow control: next state, bubble counter and all decode/PC controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    dec_nop   = 1'b0;
    dec_int   = 1'b0;
    pc_load   = 1'b0;
    pc_reset  = 1'b0;
    pred_take = 1'b0;
    fwd_sel   = '0;

    if (reset) begin
      state_d  = S_RST;
      cnt_d    = CW'(RESET_BUBBLES - 1);
      pc_reset = 1'b1;
      dec_nop  = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          stall = raw;
          if (!raw) begin
            fwd_sel = fwd_cand;
          end
          if (interrupt && int_enable) begin
            dec_int = 1'b1;
            dec_nop = 1'b1;
            state_d = S_INT;
            cnt_d   = CW'(INT_BUBBLES - 1);
          end else if (raw) begin
            dec_nop = 1'b1;
          end else if (call_ret || branch_miss) begin
            dec_nop = 1'b1;
            pc_load = 1'b1;
            state_d = S_FLUSH;
            cnt_d   = CW'(REDIRECT_BUBBLES - 1);
          end else if (pred_taken) begin
            pc_load   = 1'b1;
            stall     = 1'b1;
            pred_take = 1'b1;
            state_d   = S_PRED;
          end
        end
        S_PRED: begin
          dec_nop = 1'b1;
          state_d = S_RUN;
          if (branch_miss) begin
            pc_load = 1'b1;
            state_d = S_FLUSH;
            cnt_d   = CW'(REDIRECT_BUBBLES - 1);
          end
        end
        S_FLUSH, S_INT, S_RST: begin
          dec_nop = 1'b1;
          // INT is always entered with a full counter, so a full counter
          // marks its first cycle, where the vector address is loaded.
          if ((state_q == S_INT) && (cnt_q == CW'(INT_BUBBLES - 1))) begin
            pc_load = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
          if (branch_miss) begin
            pc_load = 1'b1;
            state_d = S_FLUSH;
            cnt_d   = CW'(REDIRECT_BUBBLES - 1);
          end
        end
        default: begin
          dec_nop = 1'b1;
          state_d = S_RST;
          cnt_d   = CW'(RESET_BUBBLES - 1);
        end
      endcase
    end

    pc_inc = !pc_reset && !pc_load && !stall;

    // A call/return taking the same cycle as branch_miss keeps the decode
    // supplied source rather than the miss-recovery path.
    if (branch_miss && !call_ret) begin
      pc_mux_sel = 3'd3;
    end else if (pred_take) begin
      pc_mux_sel = 3'd4;
    end else begin
      pc_mux_sel = {1'b0, instr_pc_mux_sel};
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard and flow controller for the RAT pipeline, replacing the fixed two-source, stall-only hazard control. It sits beside decode. It compares NSRC decode source registers against NSTAGE downstream writeback stages and, when FWD_EN is set, produces forwarding selects instead of stalling. It also sequences fixed-length bubble windows for redirects, interrupts and reset, with lengths set by parameters. It drives PC, fetch-latch and decode-squash controls.

## Interface
- REG_AW, 5, register address width
- NSRC, 2, decode source operands checked
- NSTAGE, 2, downstream writing stages tracked; stage 0 is youngest (EX)
- FWD_EN, 1, 1 = forward ready results, 0 = stall on every match
- REDIRECT_BUBBLES, 2, squash cycles after call/return/branch miss (≥1)
- INT_BUBBLES, 3, squash cycles for interrupt entry (≥1)
- RESET_BUBBLES, 2, squash cycles after reset release (≥1)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- src_addr  in  NSRC*REG_AW  decode source registers, source s at [s*REG_AW +: REG_AW]
- src_rd  in  NSRC  source s actually read
- stg_waddr  in  NSTAGE*REG_AW  destination register per stage
- stg_wen  in  NSTAGE  stage k writes a register
- stg_ready  in  NSTAGE  stage k result is available for forwarding (low for load in flight)
- instr_type  in  4  decode type: 6 = call; 7, 8, 9 = return class
- branch_miss  in  1  resolved misprediction
- pred_taken  in  1  predictor says taken
- interrupt  in  1  level interrupt request
- int_enable  in  1  interrupt flag
- instr_pc_mux_sel  in  2  decode-supplied PC source
- fwd_sel  out  NSRC*FW  per source: 0 = regfile, k+1 = stage k; FW = $clog2(NSTAGE+1)
- stall  out  1  hold PC, fetch latch and imem address mux
- dec_nop  out  1  squash decode output
- dec_int  out  1  inject interrupt op in decode
- pc_inc, pc_load, pc_reset  out  1 each  PC controls
- pc_mux_sel  out  3  PC source select

## Operation
- States: RUN, PRED, FLUSH, INT, RST.
- Each state has a bubble counter, cnt, of width $clog2(max bubble count + 1).
- Hazard match for source s:
  - hit(s,k) = src_rd[s] && stg_wen[k] && src_addr[s]==stg_waddr[k].
  - The lowest k wins.
  - Register 0 is not special.
- The winning hit forwards when FWD_EN && stg_ready[k]: fwd_sel = k+1.
- Otherwise the winning hit is a RAW hazard. raw = OR over sources.
- fwd_sel is 0 when there is no hit, when raw is set, or when the state is not RUN.
- stall = raw && state==RUN. stall is combinational and re-evaluated every cycle; no RAW state is latched.
- In RUN, events are taken in this priority order:
  1. interrupt && int_enable: dec_int=1, dec_nop=1. Next state INT, cnt=INT_BUBBLES-1.
  2. raw: dec_nop=1, stall=1. Prediction is ignored this cycle. State stays RUN.
  3. call, return or branch_miss: dec_nop=1, pc_load=1. Next state FLUSH, cnt=REDIRECT_BUBBLES-1.
  4. pred_taken: pc_load=1, stall=1. Next state PRED.
  5. Otherwise: advance. dec_nop=0, pc_inc=1.
- PRED: one cycle with dec_nop=1. pred_taken is ignored. Next state RUN.
- FLUSH, INT, RST:
  - dec_nop=1 throughout.
  - cnt decrements each cycle; at cnt==0, next state is RUN.
  - In the first INT cycle only, pc_load=1.
- pc_mux_sel:
  - 3 when branch_miss with no call or return.
  - Otherwise 4 when a pred_taken event is taken.
  - Otherwise {0, instr_pc_mux_sel}.
- pc_inc = !pc_reset && !pc_load && !stall.
- interrupt is only sampled in RUN; the requester holds the level.
- branch_miss outside RUN restarts FLUSH with cnt=REDIRECT_BUBBLES-1 and pc_load=1.

## Timing
- reset asserted:
  - Next state RST, cnt=RESET_BUBBLES-1.
  - pc_reset=1, dec_nop=1.
  - stall, pc_load, pc_inc, dec_int and fwd_sel are all 0.
  - reset dominates every event in every state, including mid-FLUSH and mid-INT.
- All outputs are combinational from state, cnt and inputs. There is zero-cycle latency from a hazard to stall.
- A redirect produces exactly 1 + REDIRECT_BUBBLES squashed decode cycles.
- An interrupt produces 1 + INT_BUBBLES squashed cycles.
- Reset produces RESET_BUBBLES squashed cycles after release.
- Counter reload happens on the transition edge; no wrap-around occurs because exit is at cnt==0.
- Simultaneous call plus branch_miss: pc_load=1 and pc_mux_sel={0, instr_pc_mux_sel}.

## Test plan
- Reset held 3 cycles, then released with RESET_BUBBLES=2 → pc_reset high 3 cycles, then dec_nop high 2 cycles, then RUN with pc_inc=1.
- src0=r5 read; stage0 writes r5 with ready=1; FWD_EN=1 → fwd_sel[0]=1, stall=0. Same with ready=0 → stall=1, dec_nop=1 until ready rises.
- Stage0 and stage1 both write r3 → fwd_sel=1 (youngest wins). With FWD_EN=0 → stall=1.
- branch_miss in RUN → pc_mux_sel=3, pc_load=1, then 2 FLUSH cycles with dec_nop=1, then RUN.
- pred_taken with no hazard → pc_mux_sel=4, stall=1; next cycle PRED with dec_nop=1 while pred_taken stays high → no second load.
- interrupt with int_enable during raw → dec_int=1, next 3 cycles INT with pc_load only in the first, stall=0.
